// File: rtl/reg_xfer_pkg.sv
// Shared definitions for the register-bus transfer controller.
//   xfer_state_t     : controller states XFER_IDLE..XFER_PRESET
//   XFER_MIN_SETTLE  : lower bound applied to the SettleCycles parameter
package reg_xfer_pkg;

    typedef enum logic [2:0] {
        XFER_IDLE    = 3'd0,
        XFER_DRIVE   = 3'd1,
        XFER_LOAD    = 3'd2,
        XFER_RELEASE = 3'd3,
        XFER_PRESET  = 3'd4
    } xfer_state_t;

    localparam int XFER_MIN_SETTLE = 1;

endpackage

// File: rtl/reg_xfer_onehot_dec.sv
// Index-to-one-hot decoder for the per-register control lines.
//   idx    in  SelBits   register index
//   en     in  1         enable; all outputs 0 when low
//   onehot out NrOfRegs  bit idx set when en=1 and idx < NrOfRegs
module reg_xfer_onehot_dec #(
    parameter int NrOfRegs = 8,
    parameter int SelBits  = 3
) (
    input  logic [SelBits-1:0]  idx,
    input  logic                en,
    output logic [NrOfRegs-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NrOfRegs; i++) begin
            onehot[i] = en && (idx == SelBits'(i));
        end
    end

endmodule

// File: rtl/reg_bus_xfer_ctrl.sv
// Upstream sequencer for the memory-stage register bank on the shared
// tri-state data bus. Executes src -> dst register moves accepted over a
// valid/ready handshake; a load only completes on a Tick cycle.
// Optional feature: define PRESET_CMD_EN to enable preset commands
// (cmd_pre=1 pulses reg_pre[dst] instead of performing a move).
//   Clock      in   clock, all state on rising edge
//   Reset      in   asynchronous, active-high
//   Tick       in   global load qualifier
//   cmd_valid  in   command offered
//   cmd_ready  out  command accepted when valid&ready at rising edge
//   cmd_src    in   source register index
//   cmd_dst    in   destination register index
//   cmd_pre    in   preset command (PRESET_CMD_EN only)
//   bus        in   snoop of shared data bus
//   reg_cs     out  per-register output disable, 1 = Hi-Z
//   reg_ce     out  per-register ClockEnable
//   reg_pre    out  per-register async preset
//   done       out  1-cycle pulse, transfer finished
//   err        out  1-cycle pulse, command rejected
//   last_data  out  value loaded by the most recent transfer
module reg_bus_xfer_ctrl
    import reg_xfer_pkg::*;
#(
    parameter int NrOfRegs     = 8,
    parameter int SelBits      = 3,
    parameter int NrOfBits     = 8,
    parameter int SettleCycles = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [SelBits-1:0]  cmd_src,
    input  logic [SelBits-1:0]  cmd_dst,
    input  logic                cmd_pre,
    input  logic [NrOfBits-1:0] bus,
    output logic [NrOfRegs-1:0] reg_cs,
    output logic [NrOfRegs-1:0] reg_ce,
    output logic [NrOfRegs-1:0] reg_pre,
    output logic                done,
    output logic                err,
    output logic [NrOfBits-1:0] last_data
);

    localparam int SettleEff = (SettleCycles < XFER_MIN_SETTLE) ? XFER_MIN_SETTLE : SettleCycles;
    localparam int CntW      = (SettleEff > 1) ? $clog2(SettleEff) : 1;

    xfer_state_t         state, state_nxt;
    logic [SelBits-1:0]  src_q, dst_q;
    logic [CntW-1:0]     cnt;
    logic                err_q;
    logic [NrOfBits-1:0] last_q;
    // Holds cmd_ready low while Reset is asserted and until the first edge after.
    logic                armed;

    logic idle, accept, reject, is_pre;
    logic src_bad, dst_bad;
    logic cs_en, ce_en, pre_en, done_c;
    logic [NrOfRegs-1:0] cs_sel;

`ifdef PRESET_CMD_EN
    assign is_pre = cmd_pre;
`else
    logic unused_pre;
    assign unused_pre = cmd_pre;
    assign is_pre     = 1'b0;
`endif

    assign accept  = cmd_valid && cmd_ready;
    assign src_bad = int'(cmd_src) >= NrOfRegs;
    assign dst_bad = int'(cmd_dst) >= NrOfRegs;
    // A preset never touches the source, so only the destination is checked.
    assign reject  = is_pre ? dst_bad : (src_bad || dst_bad || (cmd_src == cmd_dst));

    always_comb begin
        state_nxt = state;
        idle      = 1'b0;
        cs_en     = 1'b0;
        ce_en     = 1'b0;
        pre_en    = 1'b0;
        done_c    = 1'b0;
        unique case (state)
            XFER_IDLE: begin
                idle = 1'b1;
                if (accept && !reject) begin
`ifdef PRESET_CMD_EN
                    state_nxt = is_pre ? XFER_PRESET : XFER_DRIVE;
`else
                    state_nxt = XFER_DRIVE;
`endif
                end
            end
            XFER_DRIVE: begin
                cs_en = 1'b1;
                if (cnt == '0) state_nxt = XFER_LOAD;
            end
            XFER_LOAD: begin
                cs_en = 1'b1;
                ce_en = 1'b1;
                if (Tick) state_nxt = XFER_RELEASE;
            end
            XFER_RELEASE: begin
                done_c    = 1'b1;
                state_nxt = XFER_IDLE;
            end
`ifdef PRESET_CMD_EN
            XFER_PRESET: begin
                pre_en    = 1'b1;
                state_nxt = XFER_RELEASE;
            end
`endif
            default: state_nxt = XFER_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= XFER_IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
            last_q <= '0;
            armed  <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            err_q <= accept && reject;
            if (accept) begin
                src_q <= cmd_src;
                dst_q <= cmd_dst;
                cnt   <= CntW'(SettleEff - 1);
            end else if (state == XFER_DRIVE && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == XFER_LOAD && Tick) begin
                last_q <= bus;
            end
`ifdef PRESET_CMD_EN
            if (state == XFER_PRESET) begin
                last_q <= '1;
            end
`endif
        end
    end

    reg_xfer_onehot_dec #(.NrOfRegs(NrOfRegs), .SelBits(SelBits)) u_cs_dec (
        .idx(src_q), .en(cs_en), .onehot(cs_sel)
    );
    reg_xfer_onehot_dec #(.NrOfRegs(NrOfRegs), .SelBits(SelBits)) u_ce_dec (
        .idx(dst_q), .en(ce_en), .onehot(reg_ce)
    );
    reg_xfer_onehot_dec #(.NrOfRegs(NrOfRegs), .SelBits(SelBits)) u_pre_dec (
        .idx(dst_q), .en(pre_en), .onehot(reg_pre)
    );

    assign reg_cs    = ~cs_sel;
    assign cmd_ready = idle && armed;
    assign done      = done_c;
    assign err       = err_q;
    assign last_data = last_q;

endmodule

// File: tb/tb_reg_bus_xfer_ctrl.sv
// Self-checking bench for reg_bus_xfer_ctrl: directed scenarios followed by
// random traffic, all compared cycle by cycle against a transaction model.
module tb_reg_bus_xfer_ctrl;

    localparam int NR = 8;
    localparam int SB = 4;
    localparam int NB = 8;
    localparam int S  = 2;
`ifdef PRESET_CMD_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Tick;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [SB-1:0] cmd_src;
    logic [SB-1:0] cmd_dst;
    logic          cmd_pre;
    logic [NB-1:0] bus;
    logic [NR-1:0] reg_cs;
    logic [NR-1:0] reg_ce;
    logic [NR-1:0] reg_pre;
    logic          done;
    logic          err;
    logic [NB-1:0] last_data;

    reg_bus_xfer_ctrl #(
        .NrOfRegs(NR), .SelBits(SB), .NrOfBits(NB), .SettleCycles(S)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Tick(Tick),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_pre(cmd_pre),
        .bus(bus), .reg_cs(reg_cs), .reg_ce(reg_ce), .reg_pre(reg_pre),
        .done(done), .err(err), .last_data(last_data)
    );

    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction model: a command in flight, its age in cycles, and
    // whether its load (or preset) has already happened.
    bit          m_active, m_pre, m_loaded, m_err, m_armed;
    int          m_src, m_dst, m_t;
    logic [NB-1:0] m_last;

    task automatic model_reset();
        m_active = 0; m_pre = 0; m_loaded = 0; m_err = 0; m_armed = 0;
        m_src = 0; m_dst = 0; m_t = 0; m_last = '0;
    endtask

    // Applies the inputs currently driven, as the next rising edge will.
    task automatic model_advance();
        bit rdy, pre, bad;
        int s, d;
        rdy   = !m_active && m_armed;
        s     = int'(cmd_src);
        d     = int'(cmd_dst);
        m_err = 0;
        if (!m_active) begin
            if (rdy && cmd_valid) begin
                pre = PRE_EN && cmd_pre;
                bad = pre ? (d >= NR) : (s >= NR || d >= NR || s == d);
                if (bad) m_err = 1;
                else begin
                    m_active = 1; m_pre = pre; m_src = s; m_dst = d;
                    m_t = 1; m_loaded = 0;
                end
            end
        end else if (m_loaded) begin
            m_active = 0;
        end else if (m_pre) begin
            m_loaded = 1;
            m_last   = '1;
        end else if (m_t <= S) begin
            m_t++;
        end else if (Tick) begin
            m_last   = bus;
            m_loaded = 1;
        end
        m_armed = 1;
    endtask

    task automatic check_outputs();
        logic [NR-1:0] e_cs, e_ce, e_pre;
        logic          e_done;
        e_cs = '1; e_ce = '0; e_pre = '0; e_done = 0;
        if (m_active) begin
            if (m_loaded) e_done = 1;
            else if (m_pre) e_pre = NR'(1) << m_dst;
            else begin
                e_cs = ~(NR'(1) << m_src);
                if (m_t > S) e_ce = NR'(1) << m_dst;
            end
        end
        check_val("cmd_ready", 32'(cmd_ready), 32'(!m_active && m_armed));
        check_val("reg_cs", 32'(reg_cs), 32'(e_cs));
        check_val("reg_ce", 32'(reg_ce), 32'(e_ce));
        check_val("reg_pre", 32'(reg_pre), 32'(e_pre));
        check_val("done", 32'(done), 32'(e_done));
        check_val("err", 32'(err), 32'(m_err));
        check_val("last_data", 32'(last_data), 32'(m_last));
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_cs"}, 32'(reg_cs), 32'(8'hFF));
        check_val({tag, "_ce"}, 32'(reg_ce), 32'h0);
        check_val({tag, "_pre"}, 32'(reg_pre), 32'h0);
        check_val({tag, "_done"}, 32'(done), 32'h0);
        check_val({tag, "_err"}, 32'(err), 32'h0);
        check_val({tag, "_ready"}, 32'(cmd_ready), 32'h0);
        check_val({tag, "_last"}, 32'(last_data), 32'h0);
    endtask

    typedef struct {
        bit v; int src; int dst; bit pre; bit tick; logic [7:0] bus; bit rst;
    } stim_t;
    stim_t dir_q[$];

    task automatic add(input bit v, input int src, input int dst, input bit pre,
                       input bit tick, input logic [7:0] b, input int reps, input bit rst = 0);
        stim_t st;
        st.v = v; st.src = src; st.dst = dst; st.pre = pre;
        st.tick = tick; st.bus = b; st.rst = rst;
        for (int i = 0; i < reps; i++) dir_q.push_back(st);
    endtask

    task automatic do_reset();
        Reset = 1;
        #1 check_reset_vals("rst_now");
        @(negedge Clock);
        check_reset_vals("rst_hold");
        Reset = 0;
        model_reset();
    endtask

    initial begin
        stim_t st;
        int    ncyc;
        Reset = 1; Tick = 0; cmd_valid = 0; cmd_src = '0; cmd_dst = '0;
        cmd_pre = 0; bus = '0;
        model_reset();
        #1 check_reset_vals("por");
        @(negedge Clock);
        @(negedge Clock);
        check_reset_vals("por_hold");
        Reset = 0;
        model_advance();

        // Move 2->5 with bus A5, immediate Tick.
        add(1, 2, 5, 0, 1, 8'hA5, 1);
        add(0, 0, 0, 0, 1, 8'hA5, 6);
        // Same move, Tick held low four LOAD cycles.
        add(1, 2, 5, 0, 0, 8'h3C, 1);
        add(0, 0, 0, 0, 0, 8'h3C, S + 4);
        add(0, 0, 0, 0, 1, 8'h96, 1);
        add(0, 0, 0, 0, 0, 8'h00, 3);
        // Rejects: src==dst, then out-of-range dst.
        add(1, 3, 3, 0, 1, 8'h11, 1);
        add(0, 0, 0, 0, 1, 8'h11, 2);
        add(1, 1, 9, 0, 1, 8'h11, 1);
        add(0, 0, 0, 0, 1, 8'h11, 2);
        add(1, 8, 1, 0, 1, 8'h11, 1);
        add(0, 0, 0, 0, 1, 8'h11, 2);
        // Back-to-back commands with valid held high.
        add(1, 1, 4, 0, 1, 8'h5A, 16);
        add(0, 0, 0, 0, 1, 8'h00, 4);
        // Preset command (normal move when the feature is absent).
        add(1, 1, 4, 1, 1, 8'h77, 1);
        add(0, 0, 0, 0, 1, 8'h77, 6);
        // Reset while in LOAD, then a normal move.
        add(1, 0, 7, 0, 0, 8'h42, 1);
        add(0, 0, 0, 0, 0, 8'h42, S);
        add(0, 0, 0, 0, 0, 8'h42, 1, 1);
        add(0, 0, 0, 0, 1, 8'h00, 1);
        add(1, 6, 0, 0, 1, 8'hC3, 1);
        add(0, 0, 0, 0, 1, 8'hC3, 6);

        ncyc = dir_q.size() + 700;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge Clock);
            check_outputs();
            if (dir_q.size() > 0) begin
                st = dir_q.pop_front();
            end else begin
                st.v    = ($urandom_range(0, 1) == 1);
                st.src  = $urandom_range(0, 9);
                st.dst  = $urandom_range(0, 9);
                st.pre  = ($urandom_range(0, 3) == 0);
                st.tick = ($urandom_range(0, 9) < 6);
                st.bus  = 8'($urandom);
                st.rst  = m_active && !m_loaded && ($urandom_range(0, 59) == 0);
            end
            if (st.rst) do_reset();
            cmd_valid = st.v;
            cmd_src   = SB'(st.src);
            cmd_dst   = SB'(st.dst);
            cmd_pre   = st.pre;
            Tick      = st.tick;
            bus       = st.bus;
            model_advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
